fetch_ctrl: RTL

Fetch sequencer for the `pc` register and instruction memory port. It decides each cycle whether `pc` advances, holds or is redirected, via `next_pc`/`pc_stall`. It issues one instruction-memory request at a time and discards responses made stale by branches or traps. It presents fetched instructions to decode through a valid/ready register stage.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/fetch_ctrl_if.sv | 32 +++
 rtl/next_pc_sel.sv | 37 +++
 rtl/fetch_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, PC step and default vectors.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP              = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

    typedef enum logic [1:0] {
        BOOT,
        REQ,
        WAIT
    } fetch_state_t;

    // Branch targets are forced to word alignment; the low two bits are ignored.
    function automatic logic [XLEN-1:0] alignTarget(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bundle: pc register hookup, instruction-memory port, redirect inputs and decode hand-off.
interface fetch_ctrl_if;
    import riscv_pkg::*;

    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] next_pc;
    logic            pc_stall;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic            trap;
    logic            if_valid;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic            id_ready;

    // The fetch controller is the master; pc register, memory, EX and decode form the slave side.
    modport master (
        input  pc_in, imem_gnt, imem_rvalid, imem_rdata, br_taken, br_target, trap, id_ready,
        output next_pc, pc_stall, imem_req, imem_addr, if_valid, if_instr, if_pc
    );

    modport slave (
        output pc_in, imem_gnt, imem_rvalid, imem_rdata, br_taken, br_target, trap, id_ready,
        input  next_pc, pc_stall, imem_req, imem_addr, if_valid, if_instr, if_pc
    );

endinterface

// File: rtl/next_pc_sel.sv
// Priority mux for the pc register: boot vector, trap, branch, sequential advance, otherwise hold.
module next_pc_sel
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic            boot_i,
    input  logic            trap_i,
    input  logic            branch_i,
    input  logic            advance_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic            pc_stall_o
);

    // Boot outranks everything so redirects seen before the first fetch are ignored.
    always_comb begin
        next_pc_o  = pc_i;
        pc_stall_o = 1'b1;
        if (boot_i) begin
            next_pc_o  = RESET_VECTOR;
            pc_stall_o = 1'b0;
        end else if (trap_i) begin
            next_pc_o  = TRAP_VECTOR;
            pc_stall_o = 1'b0;
        end else if (branch_i) begin
            next_pc_o  = alignTarget(br_target_i);
            pc_stall_o = 1'b0;
        end else if (advance_i) begin
            next_pc_o  = pc_i + PC_STEP;
            pc_stall_o = 1'b0;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one outstanding imem request, stale-response dropping after redirects,
// and a valid/ready output register toward decode.
module fetch_ctrl
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input logic          clk,
    input logic          reset,
    fetch_ctrl_if.master bus
);

    fetch_state_t    state_q, state_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] fetchPc_q, fetchPc_d;
    logic            ifValid_q, ifValid_d;
    logic [XLEN-1:0] ifInstr_q, ifInstr_d;
    logic [XLEN-1:0] ifPc_q, ifPc_d;

    logic            inBoot;
    logic            redirect;
    logic            reqOk;
    logic            fire;
    logic [XLEN-1:0] selNextPc;
    logic            selStall;

    assign inBoot   = (state_q == BOOT);
    assign redirect = !inBoot && (bus.trap || bus.br_taken);
    // A new request only goes out when the output register has room for its answer.
    assign reqOk    = (state_q == REQ) && !redirect && (!ifValid_q || bus.id_ready);
    assign fire     = reqOk && bus.imem_gnt;

    next_pc_sel #(
        .RESET_VECTOR (RESET_VECTOR),
        .TRAP_VECTOR  (TRAP_VECTOR)
    ) u_next_pc_sel (
        .boot_i      (inBoot),
        .trap_i      (bus.trap),
        .branch_i    (bus.br_taken),
        .advance_i   (fire),
        .br_target_i (bus.br_target),
        .pc_i        (bus.pc_in),
        .next_pc_o   (selNextPc),
        .pc_stall_o  (selStall)
    );

    assign bus.next_pc   = selNextPc;
    assign bus.pc_stall  = selStall;
    assign bus.imem_req  = reqOk;
    assign bus.imem_addr = bus.pc_in;
    assign bus.if_valid  = ifValid_q;
    assign bus.if_instr  = ifInstr_q;
    assign bus.if_pc     = ifPc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= BOOT;
            drop_q    <= 1'b0;
            fetchPc_q <= '0;
            ifValid_q <= 1'b0;
            ifInstr_q <= '0;
            ifPc_q    <= '0;
        end else begin
            state_q   <= state_d;
            drop_q    <= drop_d;
            fetchPc_q <= fetchPc_d;
            ifValid_q <= ifValid_d;
            ifInstr_q <= ifInstr_d;
            ifPc_q    <= ifPc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        drop_d    = drop_q;
        fetchPc_d = fetchPc_q;
        ifValid_d = ifValid_q;
        ifInstr_d = ifInstr_q;
        ifPc_d    = ifPc_q;

        if (ifValid_q && bus.id_ready) begin
            ifValid_d = 1'b0;
        end

        unique case (state_q)
            BOOT: begin
                state_d = REQ;
            end
            REQ: begin
                if (fire) begin
                    fetchPc_d = bus.pc_in;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                // A redirect without a response leaves one stale answer in flight to swallow later.
                if (redirect) begin
                    if (bus.imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (bus.imem_rvalid) begin
                    drop_d  = 1'b0;
                    state_d = REQ;
                    if (!drop_q) begin
                        ifValid_d = 1'b1;
                        ifInstr_d = bus.imem_rdata;
                        ifPc_d    = fetchPc_q;
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        if (redirect) begin
            ifValid_d = 1'b0;
        end
    end

endmodule
